ambiente_robo: RTL and testbench
================================

AMBIENTE_ROBO -- requirements
Module: ambiente_robo

Interface
REQ-001 SHALL provide parameters: POS_X_INI, default 0, start column; POS_Y_INI, default 0, start row; DIR_INI, default 0, start heading (0=N,1=E,2=S,3=W).
REQ-002 SHALL have one clock and synchronous active-high reset: clock and reset.
REQ-003 SHALL have port: clock  in  1  system clock, rising edge active.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: avancar  in  1  command: move one cell forward.
REQ-006 SHALL have port: girar  in  1  command: rotate 90 degrees clockwise.
REQ-007 SHALL have port: recolher_entulho  in  1  command: remove rubble in the front cell.
REQ-008 SHALL have port: head  out  1  wall ahead (grid border counts as wall).
REQ-009 SHALL have port: left  out  1  wall on the left side.
REQ-010 SHALL have port: under  out  1  robot is on the exit cell.
REQ-011 SHALL have port: barrier  out  1  rubble in the front cell, with no wall in between.
REQ-012 SHALL have ports pos_x, pos_y (out, 3 each: cell coordinates) and direcao (out, 2: heading).
REQ-013 SHALL have sticky flag outputs colisao, erro_cmd and concluido (out, 1 each).
REQ-014 SHALL have ports contador_passos (out, 16), contador_giros (out, 16) and entulhos_removidos (out, 8).

Function
REQ-015 SHALL model an 8x8 grid with x increasing east and y increasing north; N moves y+1 and E moves x+1.
REQ-016 SHALL store walls as 4 bits per cell [N,E,S,W] and the initial rubble map as 64 bits; both are package constants.
REQ-017 SHALL register pos_x, pos_y, direcao, the 64-bit rubble map, the counters and the flags; all update only on the rising clock edge.
REQ-018 SHALL drive head/left/under/barrier as a combinational decode of the registered state, so a command's effect appears one cycle after it is sampled.
REQ-019 SHALL derive head from the wall bit at direcao, left from the wall bit at (direcao-1) mod 4, and barrier as the front-cell rubble bit AND NOT head.
REQ-020 SHALL accept exactly one command per cycle; if more than one command is high, it SHALL set erro_cmd and change no other state.
REQ-021 SHALL, on girar, set direcao to (direcao+1) mod 4 and increment contador_giros.
REQ-022 SHALL, on avancar with head=0 and barrier=0, move one cell and increment contador_passos.
REQ-023 SHALL, on avancar with head=1 or barrier=1, set colisao and leave position and contador_passos unchanged.
REQ-024 SHALL, on recolher_entulho with barrier=1, clear the front-cell rubble bit and increment entulhos_removidos; with barrier=0 it SHALL have no effect.
REQ-025 SHALL set concluido when position equals the package exit cell; once concluido=1, all commands SHALL be ignored.
REQ-026 SHALL saturate all counters at their maximum value, with no wrap-around.
REQ-027 SHALL treat an idle cycle (no command) as a hold of all state.

Reset
REQ-028 SHALL, on reset, load pos=(POS_X_INI,POS_Y_INI), direcao=DIR_INI and the rubble map from the package constant.
REQ-029 SHALL, on reset, clear all counters and the colisao, erro_cmd and concluido flags to 0.
REQ-030 SHALL give reset priority over any command in the same cycle, including mid-traversal and after concluido.

Structure
REQ-031 SHALL take its constants from shared package ambiente_pkg: heading encodings, wall table, initial rubble map, exit cell (default (7,7)) and grid size.
REQ-032 SHALL place the sensor decode in combinational sub-module ambiente_sensores; inputs pos, direcao, rubble map; outputs head, left, under, barrier.

Verification
REQ-033 SHALL cover reset: defaults -> pos (0,0), direcao 0, left=1, all counters 0, all flags 0.
REQ-034 SHALL cover rotation: girar for 4 cycles -> direcao 1,2,3,0, contador_giros=4, pos unchanged.
REQ-035 SHALL cover collision: 3x girar (direcao=W at (0,0)), then avancar -> head=1, colisao=1, pos (0,0), contador_passos=0.
REQ-036 SHALL cover illegal command: avancar and girar high in the same cycle -> erro_cmd=1, pos, direcao and counters unchanged.
REQ-037 SHALL cover rubble: test map with rubble at (0,1) and start (0,0) facing N -> barrier=1; avancar -> colisao=1; recolher_entulho -> barrier=0 next cycle, entulhos_removidos=1; avancar -> pos (0,1), contador_passos=1.
REQ-038 SHALL cover exit and reset: drive to (7,7) -> under=1, concluido=1; further avancar ignored; reset asserted together with girar -> initial state restored, direcao=DIR_INI.

Source files
------------

// File: rtl/ambiente_pkg.sv
// ambiente_pkg -- constants shared by the robot environment.
//   Heading encodings, the 8x8 wall table, the initial rubble map and the
//   exit cell. Cells are indexed as {y,x}. The wall table holds 4 bits per
//   cell, and the bit index equals the heading: bit0=N, bit1=E, bit2=S,
//   bit3=W. A wall bit is therefore addressed as WALLS[{y,x,dir}].
package ambiente_pkg;

   localparam int GRID_SIZE = 8;
   localparam int CELLS     = GRID_SIZE * GRID_SIZE;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } dir_e;

   localparam logic [2:0] EXIT_X = 3'd7;
   localparam logic [2:0] EXIT_Y = 3'd7;

   // Grid border on every edge cell, plus an interior partition between
   // columns 3 and 4 covering rows 0..5 (rows 6 and 7 stay open). Both
   // sides of the partition carry the wall so the map is consistent.
   function automatic logic [4*CELLS-1:0] build_walls();
      logic [4*CELLS-1:0] w;
      int base;
      w = '0;
      for (int y = 0; y < GRID_SIZE; y++) begin
         for (int x = 0; x < GRID_SIZE; x++) begin
            base = (y * GRID_SIZE + x) * 4;
            if (y == GRID_SIZE - 1) w[base + 0] = 1'b1;
            if (x == GRID_SIZE - 1) w[base + 1] = 1'b1;
            if (y == 0)             w[base + 2] = 1'b1;
            if (x == 0)             w[base + 3] = 1'b1;
            if (x == 3 && y <= 5)   w[base + 1] = 1'b1;
            if (x == 4 && y <= 5)   w[base + 3] = 1'b1;
         end
      end
      return w;
   endfunction

   localparam logic [4*CELLS-1:0] WALLS = build_walls();

   // Rubble at (0,1) -> bit 8 and at (2,4) -> bit 34.
   localparam logic [CELLS-1:0] RUBBLE_INI = 64'h0000_0004_0000_0100;

endpackage

// File: rtl/ambiente_sensores.sv
// ambiente_sensores -- combinational sensor decode for the robot.
//   pos_x_i, pos_y_i : current cell
//   dir_i            : current heading
//   entulho_i        : current rubble map, indexed {y,x}
//   head_o           : wall ahead (border counts as wall)
//   left_o           : wall on the left side
//   under_o          : robot stands on the exit cell
//   barrier_o        : rubble in the front cell with no wall between
//   front_x_o/_y_o   : coordinates of the front cell (wraps when head_o=1,
//                      consumers must qualify with head_o)
module ambiente_sensores
   import ambiente_pkg::*;
(
   input  logic [2:0]       pos_x_i,
   input  logic [2:0]       pos_y_i,
   input  dir_e             dir_i,
   input  logic [CELLS-1:0] entulho_i,
   output logic             head_o,
   output logic             left_o,
   output logic             under_o,
   output logic             barrier_o,
   output logic [2:0]       front_x_o,
   output logic [2:0]       front_y_o
);

   logic [1:0] dir_left;

   always_comb begin
      dir_left  = 2'(dir_i) - 2'd1;
      front_x_o = pos_x_i;
      front_y_o = pos_y_i;
      unique case (dir_i)
         DIR_N: front_y_o = pos_y_i + 3'd1;
         DIR_E: front_x_o = pos_x_i + 3'd1;
         DIR_S: front_y_o = pos_y_i - 3'd1;
         DIR_W: front_x_o = pos_x_i - 3'd1;
         default: ;
      endcase
      head_o    = WALLS[{pos_y_i, pos_x_i, 2'(dir_i)}];
      left_o    = WALLS[{pos_y_i, pos_x_i, dir_left}];
      under_o   = (pos_x_i == EXIT_X) && (pos_y_i == EXIT_Y);
      // The front cell is a wrapped neighbour when facing the border, so
      // the rubble bit is only meaningful when there is no wall ahead.
      barrier_o = entulho_i[{front_y_o, front_x_o}] & ~head_o;
   end

endmodule

// File: rtl/ambiente_robo.sv
// ambiente_robo -- 8x8 grid world for a rubble-clearing robot.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   avancar            : move one cell forward
//   girar              : rotate 90 degrees clockwise
//   recolher_entulho   : remove rubble from the front cell
//   head/left/under/barrier : sensor decode of the registered state
//   pos_x, pos_y, direcao   : registered position and heading
//   colisao, erro_cmd, concluido : sticky flags
//   contador_passos, contador_giros, entulhos_removidos : saturating counters
module ambiente_robo
   import ambiente_pkg::*;
#(
   parameter int POS_X_INI = 0,
   parameter int POS_Y_INI = 0,
   parameter int DIR_INI   = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        avancar,
   input  logic        girar,
   input  logic        recolher_entulho,
   output logic        head,
   output logic        left,
   output logic        under,
   output logic        barrier,
   output logic [2:0]  pos_x,
   output logic [2:0]  pos_y,
   output logic [1:0]  direcao,
   output logic        colisao,
   output logic        erro_cmd,
   output logic        concluido,
   output logic [15:0] contador_passos,
   output logic [15:0] contador_giros,
   output logic [7:0]  entulhos_removidos
);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [2:0]       pos_x_q, pos_x_d;
   logic [2:0]       pos_y_q, pos_y_d;
   dir_e             dir_q, dir_d;
   logic [CELLS-1:0] entulho_q, entulho_d;
   logic [15:0]      passos_q, passos_d;
   logic [15:0]      giros_q, giros_d;
   logic [7:0]       removidos_q, removidos_d;
   logic             colisao_q, colisao_d;
   logic             erro_q, erro_d;
   logic             concluido_q, concluido_d;

   logic             head_s, left_s, under_s, barrier_s;
   logic [2:0]       front_x, front_y;
   logic [1:0]       n_cmd;

   ambiente_sensores u_sensores (
      .pos_x_i   (pos_x_q),
      .pos_y_i   (pos_y_q),
      .dir_i     (dir_q),
      .entulho_i (entulho_q),
      .head_o    (head_s),
      .left_o    (left_s),
      .under_o   (under_s),
      .barrier_o (barrier_s),
      .front_x_o (front_x),
      .front_y_o (front_y)
   );

   always_comb begin
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      dir_d       = dir_q;
      entulho_d   = entulho_q;
      passos_d    = passos_q;
      giros_d     = giros_q;
      removidos_d = removidos_q;
      colisao_d   = colisao_q;
      erro_d      = erro_q;
      n_cmd       = {1'b0, avancar} + {1'b0, girar} + {1'b0, recolher_entulho};

      // Once the exit is reached the robot is frozen until reset.
      if (!concluido_q) begin
         if (n_cmd > 2'd1) begin
            erro_d = 1'b1;
         end else if (girar) begin
            dir_d   = dir_e'(2'(dir_q) + 2'd1);
            giros_d = sat_inc16(giros_q);
         end else if (avancar) begin
            if (head_s || barrier_s) begin
               colisao_d = 1'b1;
            end else begin
               pos_x_d  = front_x;
               pos_y_d  = front_y;
               passos_d = sat_inc16(passos_q);
            end
         end else if (recolher_entulho && barrier_s) begin
            entulho_d[{front_y, front_x}] = 1'b0;
            removidos_d = sat_inc8(removidos_q);
         end
      end

      // Looking at the next position lets concluido rise in the same cycle
      // the robot arrives, together with under.
      concluido_d = concluido_q | ((pos_x_d == EXIT_X) && (pos_y_d == EXIT_Y));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pos_x_q     <= POS_X_INI[2:0];
         pos_y_q     <= POS_Y_INI[2:0];
         dir_q       <= dir_e'(DIR_INI[1:0]);
         entulho_q   <= RUBBLE_INI;
         passos_q    <= '0;
         giros_q     <= '0;
         removidos_q <= '0;
         colisao_q   <= 1'b0;
         erro_q      <= 1'b0;
         concluido_q <= 1'b0;
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         dir_q       <= dir_d;
         entulho_q   <= entulho_d;
         passos_q    <= passos_d;
         giros_q     <= giros_d;
         removidos_q <= removidos_d;
         colisao_q   <= colisao_d;
         erro_q      <= erro_d;
         concluido_q <= concluido_d;
      end
   end

   assign head               = head_s;
   assign left               = left_s;
   assign under              = under_s;
   assign barrier            = barrier_s;
   assign pos_x              = pos_x_q;
   assign pos_y              = pos_y_q;
   assign direcao            = 2'(dir_q);
   assign colisao            = colisao_q;
   assign erro_cmd           = erro_q;
   assign concluido          = concluido_q;
   assign contador_passos    = passos_q;
   assign contador_giros     = giros_q;
   assign entulhos_removidos = removidos_q;

endmodule

// File: tb/tb_ambiente_robo.sv
// tb_ambiente_robo -- directed, table-driven bench for ambiente_robo.
module tb_ambiente_robo;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        avancar = 1'b0;
   logic        girar = 1'b0;
   logic        recolher_entulho = 1'b0;
   logic        head, left, under, barrier;
   logic [2:0]  pos_x, pos_y;
   logic [1:0]  direcao;
   logic        colisao, erro_cmd, concluido;
   logic [15:0] contador_passos, contador_giros;
   logic [7:0]  entulhos_removidos;

   ambiente_robo dut (
      .clock              (clock),
      .reset              (reset),
      .avancar            (avancar),
      .girar              (girar),
      .recolher_entulho   (recolher_entulho),
      .head               (head),
      .left               (left),
      .under              (under),
      .barrier            (barrier),
      .pos_x              (pos_x),
      .pos_y              (pos_y),
      .direcao            (direcao),
      .colisao            (colisao),
      .erro_cmd           (erro_cmd),
      .concluido          (concluido),
      .contador_passos    (contador_passos),
      .contador_giros     (contador_giros),
      .entulhos_removidos (entulhos_removidos)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0]  px;
      logic [2:0]  py;
      logic [1:0]  d;
      logic        h;
      logic        l;
      logic        u;
      logic        b;
      logic        col;
      logic        err;
      logic        con;
      logic [15:0] passos;
      logic [15:0] giros;
      logic [7:0]  ent;
   } out_t;

   typedef struct {
      string nm;
      logic  r, a, g, c;
      out_t  exp;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;
   out_t act;

   always_comb begin
      act = '{pos_x, pos_y, direcao, head, left, under, barrier,
              colisao, erro_cmd, concluido,
              contador_passos, contador_giros, entulhos_removidos};
   end

   function automatic out_t mk(int px, int py, int d, bit h, bit l, bit u, bit b,
                               bit col, bit err, bit con, int passos, int giros, int ent);
      out_t o;
      o.px = 3'(px); o.py = 3'(py); o.d = 2'(d);
      o.h = h; o.l = l; o.u = u; o.b = b;
      o.col = col; o.err = err; o.con = con;
      o.passos = 16'(passos); o.giros = 16'(giros); o.ent = 8'(ent);
      return o;
   endfunction

   function automatic string fmt(out_t o);
      return $sformatf("pos=(%0d,%0d) dir=%0d h=%0b l=%0b u=%0b b=%0b col=%0b err=%0b con=%0b passos=%0d giros=%0d ent=%0d",
                       o.px, o.py, o.d, o.h, o.l, o.u, o.b, o.col, o.err, o.con,
                       o.passos, o.giros, o.ent);
   endfunction

   task automatic add(string nm, bit r, bit a, bit g, bit c, out_t e);
      vec_t v;
      v.nm = nm; v.r = r; v.a = a; v.g = g; v.c = c; v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs at a falling edge, let the rising edge take
   // them, and compare at the following falling edge.
   task automatic step_check(string nm, bit r, bit a, bit g, bit c, out_t e);
      reset = r; avancar = a; girar = g; recolher_entulho = c;
      @(negedge clock);
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s: got %s | want %s", nm, fmt(act), fmt(e));
      end
   endtask

   out_t rst_st;

   initial begin
      rst_st = mk(0,0,0, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 0,0,0);

      // rotation
      add("reset",      1,0,0,0, rst_st);
      add("rot1",       0,0,1,0, mk(0,0,1, 0,0,0,0, 0,0,0, 0,1,0));
      add("rot2",       0,0,1,0, mk(0,0,2, 1,0,0,0, 0,0,0, 0,2,0));
      add("rot3",       0,0,1,0, mk(0,0,3, 1,1,0,0, 0,0,0, 0,3,0));
      add("rot4",       0,0,1,0, mk(0,0,0, 0,1,0,1, 0,0,0, 0,4,0));
      add("idle",       0,0,0,0, mk(0,0,0, 0,1,0,1, 0,0,0, 0,4,0));
      // collision against the west border
      add("col_rst",    1,0,0,0, rst_st);
      add("col_g1",     0,0,1,0, mk(0,0,1, 0,0,0,0, 0,0,0, 0,1,0));
      add("col_g2",     0,0,1,0, mk(0,0,2, 1,0,0,0, 0,0,0, 0,2,0));
      add("col_g3",     0,0,1,0, mk(0,0,3, 1,1,0,0, 0,0,0, 0,3,0));
      add("col_fwd",    0,1,0,0, mk(0,0,3, 1,1,0,0, 1,0,0, 0,3,0));
      // illegal command combinations
      add("ill_rst",    1,0,0,0, rst_st);
      add("ill_ag",     0,1,1,0, mk(0,0,0, 0,1,0,1, 0,1,0, 0,0,0));
      add("ill_idle",   0,0,0,0, mk(0,0,0, 0,1,0,1, 0,1,0, 0,0,0));
      add("ill_ac",     0,1,0,1, mk(0,0,0, 0,1,0,1, 0,1,0, 0,0,0));
      // interior partition between columns 3 and 4
      add("wall_rst",   1,0,0,0, rst_st);
      add("wall_g",     0,0,1,0, mk(0,0,1, 0,0,0,0, 0,0,0, 0,1,0));
      add("wall_a1",    0,1,0,0, mk(1,0,1, 0,0,0,0, 0,0,0, 1,1,0));
      add("wall_a2",    0,1,0,0, mk(2,0,1, 0,0,0,0, 0,0,0, 2,1,0));
      add("wall_a3",    0,1,0,0, mk(3,0,1, 1,0,0,0, 0,0,0, 3,1,0));
      add("wall_hit",   0,1,0,0, mk(3,0,1, 1,0,0,0, 1,0,0, 3,1,0));
      // rubble at (0,1)
      add("rub_rst",    1,0,0,0, rst_st);
      add("rub_block",  0,1,0,0, mk(0,0,0, 0,1,0,1, 1,0,0, 0,0,0));
      add("rub_clear",  0,0,0,1, mk(0,0,0, 0,1,0,0, 1,0,0, 0,0,1));
      add("rub_noop",   0,0,0,1, mk(0,0,0, 0,1,0,0, 1,0,0, 0,0,1));
      add("rub_fwd",    0,1,0,0, mk(0,1,0, 0,1,0,0, 1,0,0, 1,0,1));

      foreach (vecs[i])
         step_check(vecs[i].nm, vecs[i].r, vecs[i].a, vecs[i].g, vecs[i].c, vecs[i].exp);

      // Continue the rubble run up column 0 to the north border.
      for (int i = 0; i < 6; i++)
         step_check($sformatf("north_%0d", i), 0,1,0,0,
                    mk(0, 2+i, 0, (2+i == 7), 1, 0, 0, 1, 0, 0, 2+i, 0, 1));
      step_check("turn_east", 0,0,1,0, mk(0,7,1, 0,1,0,0, 1,0,0, 7,1,1));
      // Along row 7 to the exit; the partition does not reach this row.
      for (int i = 0; i < 7; i++)
         step_check($sformatf("east_%0d", i), 0,1,0,0,
                    mk(1+i, 7, 1, (1+i == 7), 1, (1+i == 7), 0, 1, 0, (1+i == 7), 8+i, 1, 1));

      // Frozen after the exit.
      step_check("done_a",  0,1,0,0, mk(7,7,1, 1,1,1,0, 1,0,1, 14,1,1));
      step_check("done_g",  0,0,1,0, mk(7,7,1, 1,1,1,0, 1,0,1, 14,1,1));
      step_check("done_ag", 0,1,1,0, mk(7,7,1, 1,1,1,0, 1,0,1, 14,1,1));
      // Reset wins over a simultaneous command.
      step_check("rst_g",   1,0,1,0, rst_st);
      step_check("post_rst_idle", 0,0,0,0, rst_st);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
